if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 16-bit pipelined CPU. Holds the PC and issues requests to instruction memory. Buffers one returned instruction with its PC and drives the IF/ID pipeline register, including its write enable. Handles stalls from the hazard unit and branch redirects/flushes from EX, dropping any in-flight wrong-path fetch.

---
 rtl/if_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem request, one-entry IF/ID output buffer.
// Optional fetch/flush performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_unit #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  PC_STEP  = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_rvalid,
    input  logic [15:0]         imem_rdata,
    output logic                if_valid,
    output logic [15:0]         if_instruction,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic                if_id_write_enable
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]         fetch_count,
    output logic [15:0]         flush_count
`endif
);

    // state     | meaning
    // S_IDLE    | leaving reset, no request
    // S_WAIT    | request at pc outstanding (withheld while buffer full and stalled)
    // S_FULL    | buffer full and stalled, no request
    // S_DISCARD | waiting for a wrong-path response to drop
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_FULL    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   hold_addr_q, hold_addr_d;
    logic                  valid_q, valid_d;
    logic [15:0]           instr_q, instr_d;
    logic [PC_WIDTH-1:0]   ifpc_q, ifpc_d;
    logic                  buf_free;
    logic                  req;
    logic                  load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            hold_addr_q <= '0;
            valid_q     <= 1'b0;
            instr_q     <= 16'h0000;
            ifpc_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_addr_q <= hold_addr_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            ifpc_q      <= ifpc_d;
        end
    end

    // A new fetch is only presented when the buffer is guaranteed free at the response edge.
    assign buf_free = ~valid_q | ~stall;
    assign req      = (state_q == S_DISCARD) | ((state_q == S_WAIT) & buf_free);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_addr_d = hold_addr_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        ifpc_d      = ifpc_q;
        load        = 1'b0;

        if (valid_q & ~stall) begin
            valid_d = 1'b0;
        end

        if (branch_taken) begin
            valid_d = 1'b0;
            pc_d    = branch_target;
            if (req & ~imem_rvalid) begin
                state_d = S_DISCARD;
                if (state_q == S_WAIT) begin
                    hold_addr_d = pc_q;
                end
            end else begin
                state_d = S_WAIT;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (req & imem_rvalid) begin
                        load    = 1'b1;
                        valid_d = 1'b1;
                        instr_d = imem_rdata;
                        ifpc_d  = pc_q;
                        pc_d    = pc_q + PC_WIDTH'(PC_STEP);
                    end else if (~buf_free) begin
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (~stall) begin
                        state_d = S_WAIT;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        state_d = S_WAIT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign imem_req           = req;
    assign imem_addr          = (state_q == S_DISCARD) ? hold_addr_q : pc_q;
    assign if_valid           = valid_q;
    assign if_instruction     = instr_q;
    assign if_pc              = ifpc_q;
    assign if_id_write_enable = valid_q & ~stall & ~branch_taken;

`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (load && fetch_cnt_q != 16'hFFFF) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end
            if (branch_taken && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: cycle vector table plus hand sequences, with a scoreboard of
// expected consumed PCs checked whenever the IF/ID write enable fires.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instruction;
    logic [15:0] if_pc;
    logic        if_id_write_enable;
`ifdef IF_PERF_CNT_EN
    logic [15:0] fetch_count;
    logic [15:0] flush_count;
`endif

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .stall              (stall),
        .branch_taken       (branch_taken),
        .branch_target      (branch_target),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_rvalid        (imem_rvalid),
        .imem_rdata         (imem_rdata),
        .if_valid           (if_valid),
        .if_instruction     (if_instruction),
        .if_pc              (if_pc),
        .if_id_write_enable (if_id_write_enable)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count        (fetch_count),
        .flush_count        (flush_count)
`endif
    );

    // Memory model: responds once the request has been held mem_lat cycles; data = 16'h1000 + addr.
    int unsigned mem_lat = 0;
    int unsigned mem_cnt;
    logic        force_rv = 1'b0;

    assign imem_rvalid = force_rv | (imem_req && (mem_cnt >= mem_lat));
    assign imem_rdata  = force_rv ? 16'hDEAD : 16'h1000 + imem_addr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)                     mem_cnt <= 0;
        else if (imem_req && !imem_rvalid) mem_cnt <= mem_cnt + 1;
        else                              mem_cnt <= 0;
    end

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic b, input logic [15:0] t);
        logic [15:0] exp_pc;
        logic [15:0] exp_instr;
        @(negedge clk);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        #2;
        if (if_id_write_enable) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual_pc=%h required=no_consume", if_pc);
            end else begin
                exp_pc    = sb.pop_front();
                exp_instr = 16'h1000 + exp_pc;
                chk("sb_pc", {16'h0, if_pc}, {16'h0, exp_pc});
                chk("sb_instr", {16'h0, if_instruction}, {16'h0, exp_instr});
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n       = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        force_rv      = 1'b0;
        mem_lat       = 0;
        #2;
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_instr", {16'h0, if_instruction}, 32'h0);
        chk("rst_pc", {16'h0, if_pc}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        sb.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        e_valid;
        logic [15:0] e_pc;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_we;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [15:0] exp16;

        // Streaming with a 3-cycle stall holding pc=2 (zero-latency memory).
        tbl[0]  = '{1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0, 1'b1, 16'h1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h1, 1'b1, 16'h2, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h2, 1'b0, 16'h0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h2, 1'b0, 16'h0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h2, 1'b0, 16'h0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h2, 1'b0, 16'h0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h3, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h3, 1'b1, 16'h4, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h4, 1'b1, 16'h5, 1'b1};

        do_reset();
        sb = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].stall, tbl[i].br, tbl[i].tgt);
            chk($sformatf("t%0d_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].e_valid});
            chk($sformatf("t%0d_req", i), {31'h0, imem_req}, {31'h0, tbl[i].e_req});
            chk($sformatf("t%0d_we", i), {31'h0, if_id_write_enable}, {31'h0, tbl[i].e_we});
            if (tbl[i].e_valid) begin
                exp16 = 16'h1000 + tbl[i].e_pc;
                chk($sformatf("t%0d_pc", i), {16'h0, if_pc}, {16'h0, tbl[i].e_pc});
                chk($sformatf("t%0d_instr", i), {16'h0, if_instruction}, {16'h0, exp16});
            end
            if (tbl[i].e_req) begin
                chk($sformatf("t%0d_addr", i), {16'h0, imem_addr}, {16'h0, tbl[i].e_addr});
            end
        end
        chk("s1_sb_empty", sb.size(), 0);

        // Branch to 0x0040 while the request for pc=5 is outstanding; pc=5 data must be dropped.
        do_reset();
        sb = '{16'h0, 16'h1, 16'h2, 16'h3, 16'h4, 16'h40};
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #1 mem_lat = 2;
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0040);
        chk("br_req", {31'h0, imem_req}, 32'h1);
        chk("br_addr", {16'h0, imem_addr}, 32'h5);
        chk("br_valid", {31'h0, if_valid}, 32'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("disc_req", {31'h0, imem_req}, 32'h1);
        chk("disc_addr", {16'h0, imem_addr}, 32'h5);
        chk("disc_rvalid", {31'h0, imem_rvalid}, 32'h1);
        step(1'b0, 1'b0, 16'h0);
        chk("tgt_addr", {16'h0, imem_addr}, 32'h40);
        chk("tgt_valid", {31'h0, if_valid}, 32'h0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("tgt_first_valid", {31'h0, if_valid}, 32'h1);
        chk("tgt_first_pc", {16'h0, if_pc}, 32'h40);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch", {16'h0, fetch_count}, 32'd6);
        chk("perf_flush", {16'h0, flush_count}, 32'd1);
`endif
        chk("s2_sb_empty", sb.size(), 0);

        // Branch and stall in the same cycle with a valid buffer.
        do_reset();
        sb = '{16'h80};
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h0080);
        chk("bs_valid", {31'h0, if_valid}, 32'h1);
        chk("bs_we", {31'h0, if_id_write_enable}, 32'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("bs_flushed", {31'h0, if_valid}, 32'h0);
        chk("bs_req", {31'h0, imem_req}, 32'h1);
        chk("bs_addr", {16'h0, imem_addr}, 32'h80);
        step(1'b0, 1'b0, 16'h0);
        chk("bs_pc", {16'h0, if_pc}, 32'h80);
        chk("s3_sb_empty", sb.size(), 0);

        // PC wrap from 0xFFFF to 0x0000.
        do_reset();
        sb = '{16'hFFFF, 16'h0000};
        step(1'b0, 1'b1, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0);
        chk("wrap_addr_ffff", {16'h0, imem_addr}, 32'hFFFF);
        step(1'b0, 1'b0, 16'h0);
        chk("wrap_addr_0", {16'h0, imem_addr}, 32'h0);
        chk("wrap_req", {31'h0, imem_req}, 32'h1);
        step(1'b0, 1'b0, 16'h0);
        chk("s4_sb_empty", sb.size(), 0);

        // Reset in the middle of a request; a stray response in S_IDLE must be ignored.
        do_reset();
        mem_lat = 3;
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("mr_req", {31'h0, imem_req}, 32'h1);
        chk("mr_addr", {16'h0, imem_addr}, 32'h0);
        step(1'b0, 1'b0, 16'h0);
        do_reset();
        force_rv = 1'b1;
        step(1'b0, 1'b0, 16'h0);
        chk("stray_valid", {31'h0, if_valid}, 32'h0);
        @(posedge clk);
        #1 force_rv = 1'b0;
        sb = '{16'h0};
        step(1'b0, 1'b0, 16'h0);
        chk("after_stray_valid", {31'h0, if_valid}, 32'h0);
        chk("after_stray_addr", {16'h0, imem_addr}, 32'h0);
        chk("after_stray_req", {31'h0, imem_req}, 32'h1);
        step(1'b0, 1'b0, 16'h0);
        chk("after_stray_instr", {16'h0, if_instruction}, 32'h1000);
        chk("s5_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
